freecell_player: RTL and testbench



---
 rtl/freecell_player.sv | 144 ++++++++++++++
 tb/tb_freecell_player.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/freecell_player.sv
// FreeCell engine: 8 tableau columns, 4 free cells, 4 home piles.
// Latency: one move is evaluated per rising edge; accepted/win are registered (1 cycle).
// Backpressure: none; illegal moves are dropped and accepted stays low for that cycle.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-high; reloads the default deal
//   source   - 0-7 column, 8-11 free cell, 12-15 home (never a legal source)
//   dest     - 0-7 column, 8-11 free cell, 12-15 home (LSBs ignored)
//   win      - all four home piles hold their king
//   accepted - previous edge applied a legal move
module freecell_player #(
  parameter int DEPTH = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] source,
  input  logic [3:0] dest,
  output logic       win,
  output logic       accepted
);

  // card = {suit[1:0], rank[3:0]}; rank 0 means "no card"
  typedef logic [5:0] card_t;

  card_t      col_q  [8][DEPTH];
  card_t      col_d  [8][DEPTH];
  logic [4:0] len_q  [8];
  logic [4:0] len_d  [8];
  card_t      cell_q [4];
  card_t      cell_d [4];
  logic [3:0] home_q [4];
  logic [3:0] home_d [4];
  logic       win_q, win_d;
  logic       acc_q;

  card_t      src_card;
  card_t      dst_top;
  logic       src_ok;
  logic       dst_ok;
  logic       legal;

  // Default deal: card k has rank 13-k/4, suit k%4, column k%8, height k/8.
  function automatic card_t deal_card(input int c, input int p);
    int k;
    k = p * 8 + c;
    if (p < ((c < 4) ? 7 : 6)) deal_card = {2'(k % 4), 4'(13 - k / 4)};
    else                       deal_card = '0;
  endfunction

  // Diamonds (01) and hearts (10) are red.
  function automatic logic is_red(input card_t c);
    is_red = c[5] ^ c[4];
  endfunction

  // Card being moved and whether the source actually holds one.
  always_comb begin
    src_card = '0;
    src_ok   = 1'b0;
    if (!source[3]) begin
      if (len_q[source[2:0]] != 5'd0) begin
        src_ok   = 1'b1;
        src_card = col_q[source[2:0]][len_q[source[2:0]] - 5'd1];
      end
    end else if (!source[2]) begin
      src_card = cell_q[source[1:0]];
      src_ok   = (cell_q[source[1:0]][3:0] != 4'd0);
    end
  end

  // Destination acceptance for src_card.
  always_comb begin
    dst_top = '0;
    dst_ok  = 1'b0;
    if (dest[3:2] == 2'b11) begin
      dst_ok = (src_card[3:0] == home_q[src_card[5:4]] + 4'd1);
    end else if (dest[3]) begin
      dst_ok = (cell_q[dest[1:0]][3:0] == 4'd0);
    end else if (len_q[dest[2:0]] == 5'(DEPTH)) begin
      dst_ok = 1'b0;
    end else if (len_q[dest[2:0]] == 5'd0) begin
      dst_ok = 1'b1;
    end else begin
      dst_top = col_q[dest[2:0]][len_q[dest[2:0]] - 5'd1];
      dst_ok  = (dst_top[3:0] == src_card[3:0] + 4'd1) &&
                (is_red(dst_top) != is_red(src_card));
    end
  end

  // Unknown move bits are treated as a non-move in 4-state simulation.
  assign legal = !$isunknown({source, dest}) && src_ok && dst_ok && (source != dest);

  // Next state: pop from source, push to destination in the same edge.
  always_comb begin
    col_d  = col_q;
    len_d  = len_q;
    cell_d = cell_q;
    home_d = home_q;
    if (legal) begin
      if (!source[3]) len_d[source[2:0]]  = len_q[source[2:0]] - 5'd1;
      else            cell_d[source[1:0]] = '0;

      if (dest[3:2] == 2'b11) begin
        home_d[src_card[5:4]] = src_card[3:0];
      end else if (dest[3]) begin
        cell_d[dest[1:0]] = src_card;
      end else begin
        col_d[dest[2:0]][len_q[dest[2:0]]] = src_card;
        len_d[dest[2:0]] = len_q[dest[2:0]] + 5'd1;
      end
    end
    // Taken from next-state so win rises with the edge that homes the last king.
    win_d = (home_d[0] == 4'd13) && (home_d[1] == 4'd13) &&
            (home_d[2] == 4'd13) && (home_d[3] == 4'd13);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 8; c++) begin
        for (int p = 0; p < DEPTH; p++) begin
          col_q[c][p] <= deal_card(c, p);
        end
        len_q[c] <= (c < 4) ? 5'd7 : 5'd6;
      end
      for (int i = 0; i < 4; i++) begin
        cell_q[i] <= '0;
        home_q[i] <= '0;
      end
      win_q <= 1'b0;
      acc_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      len_q  <= len_d;
      cell_q <= cell_d;
      home_q <= home_d;
      win_q  <= win_d;
      acc_q  <= legal;
    end
  end

  assign win      = win_q;
  assign accepted = acc_q;

endmodule

// File: tb/tb_freecell_player.sv
// Bench for freecell_player: directed moves, a queue-based game model compared
// every cycle, plus literal expectations for each directed move.
module tb_freecell_player;

  localparam int DEPTH = 20;

  logic       clock;
  logic       reset;
  logic [3:0] source;
  logic [3:0] dest;
  logic       win;
  logic       accepted;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  freecell_player #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .source   (source),
    .dest     (dest),
    .win      (win),
    .accepted (accepted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model: cards are suit*16+rank, 0 = none ----------------
  int mcol [8][$];
  int mcell[4];
  int mhome[4];
  bit exp_acc;
  bit exp_win;

  function automatic bit red(input int c);
    return (c / 16 == 1) || (c / 16 == 2);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 8; c++) mcol[c].delete();
    for (int k = 0; k < 52; k++) mcol[k % 8].push_back((k % 4) * 16 + 13 - k / 4);
    for (int i = 0; i < 4; i++) begin
      mcell[i] = 0;
      mhome[i] = 0;
    end
    exp_acc = 0;
    exp_win = 0;
  endtask

  task automatic m_step();
    int s, d, card, top, n;
    bit ok;
    ok   = !$isunknown({source, dest});
    s    = int'(source);
    d    = int'(dest);
    card = 0;
    if (ok) begin
      if (s < 8) begin
        n = mcol[s].size();
        if (n > 0) card = mcol[s][n-1];
        else       ok = 0;
      end else if (s < 12) begin
        card = mcell[s-8];
        if (card == 0) ok = 0;
      end else begin
        ok = 0;
      end
    end
    if (ok && s == d) ok = 0;
    if (ok) begin
      if (d >= 12) ok = (card % 16 == mhome[card / 16] + 1);
      else if (d >= 8) ok = (mcell[d-8] == 0);
      else begin
        n = mcol[d].size();
        if (n == DEPTH) ok = 0;
        else if (n > 0) begin
          top = mcol[d][n-1];
          ok  = (top % 16 == card % 16 + 1) && (red(top) != red(card));
        end
      end
    end
    if (ok) begin
      if (s < 8) void'(mcol[s].pop_back());
      else       mcell[s-8] = 0;
      if (d >= 12)     mhome[card / 16] = card % 16;
      else if (d >= 8) mcell[d-8] = card;
      else             mcol[d].push_back(card);
    end
    exp_acc = ok;
    exp_win = (mhome[0] == 13) && (mhome[1] == 13) && (mhome[2] == 13) && (mhome[3] == 13);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) m_reset();
    else       m_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("model_accepted", int'(accepted), int'(exp_acc));
      chk("model_win", int'(win), int'(exp_win));
    end
  end

  // Drive one move, then check accepted against a hand-computed literal.
  task automatic mv(input logic [3:0] s, input logic [3:0] d, input int lit, input string name);
    source = s;
    dest   = d;
    @(posedge clock);
    #1;
    chk(name, int'(accepted), lit);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    source = 4'd0;
    dest   = 4'd0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    #12;
    chk("reset_accepted", int'(accepted), 0);
    chk("reset_win", int'(win), 0);
    @(negedge clock);
    reset  = 1'b0;
    chk_en = 1;

    // Basic home / free-cell traffic from the deal.
    mv(4'd0,  4'd12, 1, "ac_home");
    mv(4'd0,  4'd12, 0, "3c_home_early");
    mv(4'd4,  4'd12, 1, "2c_home");
    mv(4'd5,  4'd12, 0, "2d_home_early");
    mv(4'd1,  4'd8,  1, "ad_to_cell_a");
    mv(4'd2,  4'd8,  0, "cell_a_occupied");
    mv(4'd8,  4'd12, 1, "ad_cell_home");
    mv(4'd8,  4'd12, 0, "cell_a_empty");
    mv(4'd5,  4'd13, 1, "2d_home_alias");
    mv(4'd12, 4'd3,  0, "home_as_source");
    mv(4'd0,  4'd0,  0, "same_column");
    mv(4'bx,  4'd2,  0, "unknown_source");

    // Colour and rank rules onto an exposed 3 of clubs.
    do_reset();
    mv(4'd0, 4'd8,  1, "ac_to_cell");
    mv(4'd5, 4'd0,  1, "2d_on_3c");
    mv(4'd0, 4'd9,  1, "2d_to_cell_b");
    mv(4'd4, 4'd0,  0, "2c_on_3c");
    mv(4'd7, 4'd0,  0, "2s_on_3c");
    mv(4'd1, 4'd0,  0, "ad_on_3c");
    mv(4'd6, 4'd0,  1, "2h_on_3c");
    mv(4'd8, 4'd8,  0, "cell_to_itself");
    mv(4'd9, 4'd8,  0, "cell_dest_full");
    mv(4'd8, 4'd15, 1, "ac_cell_home");

    // Full game: odd ranks sit in columns 1-4, even ranks in 5-8, one suit each.
    do_reset();
    for (int r = 1; r <= 13; r++) begin
      for (int s = 0; s < 4; s++) begin
        mv(4'((r % 2 == 1) ? s : s + 4), 4'd12, 1, "game_move");
        chk("game_win", int'(win), (r == 13 && s == 3) ? 1 : 0);
      end
    end
    mv(4'd0, 4'd12, 0, "after_win_empty");
    mv(4'd8, 4'd3,  0, "after_win_cell");
    chk("win_holds", int'(win), 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("async_reset_win", int'(win), 0);
    chk("async_reset_accepted", int'(accepted), 0);
    #1 reset = 1'b0;
    mv(4'd0, 4'd12, 1, "redeal_ac_home");
    mv(4'd3, 4'd12, 1, "redeal_as_home");
    mv(4'd7, 4'd12, 1, "redeal_2s_home");
    chk("redeal_win", int'(win), 0);

    @(negedge clock);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
